pet_action_scheduler: RTL and testbench
=======================================

Name: pet_action_scheduler

Overview:
- Sequences the virtual-pet stat datapath (fsm_states).
- Arbitrates four user/sensor action requests (feed, heal, play, sleep) into one-cycle grant strobes.
- Round-robin order, with a per-grant cooldown measured in seconds.
- Generates the 1 s tick and a rotating decay strobe that tells the datapath which stat to decrement.

Parameters:
TICK_DIV, 10000, clk cycles per second tick (min 2)
DECAY_SECS, 5, seconds between successive decay strobes (min 1)
COOLDOWN_TICKS, 2, seconds of cooldown after each grant (0 = no cooldown)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-low
req  in  4  level requests, already synchronised; bit0 feed, bit1 heal, bit2 play, bit3 sleep
sleeping  in  1  pet-asleep level from datapath; used only with SLEEP_LOCK_EN
grant  out  4  one-hot, one-cycle action strobe; same bit mapping as req
decay_stb  out  1  one-cycle strobe: decrement the stat selected by decay_sel
decay_sel  out  3  stat index: 0 food, 1 sleep, 2 fun, 3 happy, 4 health
sec_tick  out  1  one-cycle pulse every TICK_DIV cycles
state  out  2  arbiter state for debug: 0 IDLE, 1 GRANT, 2 COOLDOWN

Behaviour:
- Reset (rst=0, async): all counters 0, state IDLE, rr_ptr 0, decay_sel 0, grant/decay_stb/sec_tick 0. Reset mid-grant or mid-cooldown returns to IDLE immediately; nothing is retained.
- Prescaler: cnt counts 0..TICK_DIV-1 and wraps. sec_tick=1 in the cycle cnt==TICK_DIV-1.
- Decay counter sec_cnt (0..DECAY_SECS-1):
  - Advances on sec_tick.
  - decay_stb=1 in the sec_tick cycle where sec_cnt==DECAY_SECS-1.
  - decay_sel holds its value during the strobe and advances after it: 0,1,2,3,4,0...
- Arbiter FSM:
  - IDLE: if (req_eff != 0) and decay_stb==0, latch winner = first set bit of req_eff searching upward from rr_ptr mod 4; go to GRANT. If decay_stb==1, stay in IDLE; the request is re-evaluated next cycle.
  - GRANT (exactly 1 cycle): grant = onehot(winner); rr_ptr <= winner+1 mod 4; cd_cnt <= COOLDOWN_TICKS. Next state is COOLDOWN, or IDLE if COOLDOWN_TICKS==0.
  - COOLDOWN: cd_cnt decrements on each sec_tick. When it decrements from 1 to 0, go to IDLE. Requests are ignored here, not queued.
- Latency: req sampled in IDLE at cycle n gives grant at cycle n+1. grant is decoded from registered state and winner; no combinational path from req.
- A request held continuously is re-granted once per cooldown period; with several requests held, they are served in round-robin order.
- A request that deasserts before IDLE samples it is lost; no grant is issued.
- At most one grant bit is ever high. grant and decay_stb are never high in the same cycle.
- req_eff = req unless SLEEP_LOCK_EN is defined.

Optional Feature:
Macro PET_SLEEP_LOCK_EN.
- Defined, while sleeping=1:
  - req_eff = req & 4'b1010; feed and play are masked, heal and sleep are allowed.
  - decay rotation skips index 1; the sleep stat does not decay while asleep (e.g. 0,2,3,4,0 while asleep).
- Not defined: sleeping is ignored, req_eff = req, rotation is always 0..4.

Decomposition:
- Shared package pet_pkg holds:
  - action indices ACT_FEED=0, ACT_HEAL=1, ACT_PLAY=2, ACT_SLEEP=3
  - stat indices STAT_FOOD..STAT_HEALTH (0..4)
  - state encodings S_IDLE/S_GRANT/S_COOLDOWN
- One natural sub-module, pet_tick_gen: prescaler, sec_cnt, decay_stb and decay_sel rotation.
- The arbiter FSM stays in the top module.

Test Plan (TICK_DIV=4, DECAY_SECS=2, COOLDOWN_TICKS=1):
- Reset release, req=0 -> sec_tick every 4 cycles; decay_stb every 8 cycles; decay_sel 0,1,2,3,4,0; grant stays 0.
- req=0001 for 1 cycle in IDLE -> grant=0001 exactly one cycle later, for 1 cycle; state GRANT then COOLDOWN; IDLE after the next sec_tick.
- req=1111 held -> successive grants 0001,0010,0100,1000,0001, one per cooldown period.
- req=0100 rises in a decay_stb cycle -> no grant that cycle; grant=0100 arrives one cycle late.
- Drive rst=0 during COOLDOWN -> state=0, all outputs 0 immediately (asynchronously); after release, req=0010 is granted one cycle later.
- PET_SLEEP_LOCK_EN, sleeping=1, req=0101 -> only 0000 and no feed/play grants; req=0010 grants heal; decay_sel sequence skips 1.

Source files
------------

// File: rtl/pet_pkg.sv
// Shared action/stat indices, arbiter state encoding and the round-robin pick helper
// for the virtual-pet action scheduler.
package pet_pkg;

    localparam logic [1:0] ACT_FEED  = 2'd0;
    localparam logic [1:0] ACT_HEAL  = 2'd1;
    localparam logic [1:0] ACT_PLAY  = 2'd2;
    localparam logic [1:0] ACT_SLEEP = 2'd3;

    localparam logic [2:0] STAT_FOOD   = 3'd0;
    localparam logic [2:0] STAT_SLEEP  = 3'd1;
    localparam logic [2:0] STAT_FUN    = 3'd2;
    localparam logic [2:0] STAT_HAPPY  = 3'd3;
    localparam logic [2:0] STAT_HEALTH = 3'd4;

    // Actions still allowed while the pet is asleep.
    localparam logic [3:0] SLEEP_LOCK_MASK = (4'b0001 << ACT_HEAL) | (4'b0001 << ACT_SLEEP);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_GRANT    = 2'd1,
        S_COOLDOWN = 2'd2
    } arb_state_e;

    // First set bit of req searching upward (mod 4) from ptr; caller ensures req != 0.
    function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
        logic [1:0] idx;
        rr_pick = ptr;
        for (int i = 3; i >= 0; i--) begin
            idx = ptr + 2'(i);
            if (req[idx]) rr_pick = idx;
        end
    endfunction

endpackage

// File: rtl/pet_tick_gen.sv
// Second prescaler, decay second counter and rotating decay-stat selector.
// skip_sleep_i drops the sleep stat from the rotation (driven only with PET_SLEEP_LOCK_EN).
module pet_tick_gen
    import pet_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 10000,
    parameter int unsigned DECAY_SECS = 5
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       skip_sleep_i,
    output logic       sec_tick_o,
    output logic       decay_stb_o,
    output logic [2:0] decay_sel_o
);

    localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned SecW = (DECAY_SECS > 1) ? $clog2(DECAY_SECS) : 1;

    logic [CntW-1:0] cnt_q, cnt_d;
    logic [SecW-1:0] sec_cnt_q, sec_cnt_d;
    logic [2:0]      sel_q, sel_d;
    logic            sec_last;

    assign sec_tick_o  = (cnt_q == CntW'(TICK_DIV - 1));
    assign sec_last    = (sec_cnt_q == SecW'(DECAY_SECS - 1));
    assign decay_stb_o = sec_tick_o && sec_last;
    assign decay_sel_o = sel_q;

    always_comb begin
        cnt_d     = sec_tick_o ? '0 : cnt_q + CntW'(1);
        sec_cnt_d = sec_cnt_q;
        sel_d     = sel_q;
        if (sec_tick_o) begin
            sec_cnt_d = sec_last ? '0 : sec_cnt_q + SecW'(1);
        end
        // Selector holds through the strobe and moves on afterwards.
        if (decay_stb_o) begin
            sel_d = (sel_q == STAT_HEALTH) ? STAT_FOOD : sel_q + 3'd1;
            if (skip_sleep_i && (sel_d == STAT_SLEEP)) sel_d = STAT_FUN;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q     <= '0;
            sec_cnt_q <= '0;
            sel_q     <= STAT_FOOD;
        end else begin
            cnt_q     <= cnt_d;
            sec_cnt_q <= sec_cnt_d;
            sel_q     <= sel_d;
        end
    end

endmodule

// File: rtl/pet_action_scheduler.sv
// Round-robin action arbiter with per-grant cooldown, plus tick/decay generation.
// Optional PET_SLEEP_LOCK_EN: while sleeping_i, mask feed/play and skip sleep-stat decay.
module pet_action_scheduler
    import pet_pkg::*;
#(
    parameter int unsigned TICK_DIV       = 10000,
    parameter int unsigned DECAY_SECS     = 5,
    parameter int unsigned COOLDOWN_TICKS = 2
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [3:0] req_i,
    input  logic       sleeping_i,
    output logic [3:0] grant_o,
    output logic       decay_stb_o,
    output logic [2:0] decay_sel_o,
    output logic       sec_tick_o,
    output logic [1:0] state_o
);

    localparam int unsigned CdW = (COOLDOWN_TICKS > 0) ? $clog2(COOLDOWN_TICKS + 1) : 1;

    arb_state_e     state_q, state_d;
    logic [1:0]     winner_q, winner_d;
    logic [1:0]     rr_ptr_q, rr_ptr_d;
    logic [CdW-1:0] cd_cnt_q, cd_cnt_d;
    logic [3:0]     req_eff;
    logic           skip_sleep;

`ifdef PET_SLEEP_LOCK_EN
    assign req_eff    = sleeping_i ? (req_i & SLEEP_LOCK_MASK) : req_i;
    assign skip_sleep = sleeping_i;
`else
    logic unused_sleeping;
    assign unused_sleeping = sleeping_i;
    assign req_eff         = req_i;
    assign skip_sleep      = 1'b0;
`endif

    pet_tick_gen #(
        .TICK_DIV   (TICK_DIV),
        .DECAY_SECS (DECAY_SECS)
    ) u_tick_gen (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .skip_sleep_i (skip_sleep),
        .sec_tick_o   (sec_tick_o),
        .decay_stb_o  (decay_stb_o),
        .decay_sel_o  (decay_sel_o)
    );

    assign state_o = state_q;

    always_comb begin
        state_d  = state_q;
        winner_d = winner_q;
        rr_ptr_d = rr_ptr_q;
        cd_cnt_d = cd_cnt_q;
        grant_o  = 4'b0000;
        unique case (state_q)
            S_IDLE: begin
                // Decay strobe cycles defer arbitration by one cycle.
                if ((req_eff != 4'b0000) && !decay_stb_o) begin
                    winner_d = rr_pick(req_eff, rr_ptr_q);
                    state_d  = S_GRANT;
                end
            end
            S_GRANT: begin
                grant_o  = 4'b0001 << winner_q;
                rr_ptr_d = winner_q + 2'd1;
                cd_cnt_d = CdW'(COOLDOWN_TICKS);
                state_d  = (COOLDOWN_TICKS == 0) ? S_IDLE : S_COOLDOWN;
            end
            S_COOLDOWN: begin
                if (sec_tick_o) begin
                    cd_cnt_d = cd_cnt_q - CdW'(1);
                    if (cd_cnt_q == CdW'(1)) state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            winner_q <= 2'd0;
            rr_ptr_q <= 2'd0;
            cd_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            winner_q <= winner_d;
            rr_ptr_q <= rr_ptr_d;
            cd_cnt_q <= cd_cnt_d;
        end
    end

endmodule

// File: tb/tb_pet_action_scheduler.sv
// Randomized scoreboard bench for pet_action_scheduler (TICK_DIV=4, DECAY_SECS=2, COOLDOWN=1).
module tb_pet_action_scheduler;

    localparam int TD = 4;
    localparam int DS = 2;
    localparam int CD = 1;

    logic       clk = 1'b0;
    logic       rst_ni = 1'b0;
    logic [3:0] req = 4'b0000;
    logic       sleeping = 1'b0;
    logic [3:0] grant_o;
    logic       decay_stb_o;
    logic [2:0] decay_sel_o;
    logic       sec_tick_o;
    logic [1:0] state_o;

    pet_action_scheduler #(
        .TICK_DIV       (TD),
        .DECAY_SECS     (DS),
        .COOLDOWN_TICKS (CD)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .req_i       (req),
        .sleeping_i  (sleeping),
        .grant_o     (grant_o),
        .decay_stb_o (decay_stb_o),
        .decay_sel_o (decay_sel_o),
        .sec_tick_o  (sec_tick_o),
        .state_o     (state_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [3:0] g;
    } gexp_t;

    int    total = 0;
    int    bad = 0;
    gexp_t gq[$];
    int    sq[$];

    // Reference model state (cycle index k counts clock periods since reset release)
    int k = 0;
    int idle_from = 0;
    int grant_cyc = -1;
    int ptr = 0;
    int msel = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at t=%0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic bit is_decay(input int c);
        return (c % (TD * DS)) == (TD * DS - 1);
    endfunction

    // Monitor: checks cycle mk outputs against time-based rules and the scoreboard queues.
    int mk = 0;
    always begin
        gexp_t e;
        int    s;
        logic [3:0] eg;
        @(posedge clk);
        #1;
        if (!rst_ni) begin
            mk = 0;
        end else begin
            mk++;
            chk("sec_tick", int'(sec_tick_o), int'((mk % TD) == TD - 1));
            chk("decay_stb", int'(decay_stb_o), int'(is_decay(mk)));
            if (decay_stb_o) begin
                if (sq.size() == 0) begin
                    chk("decay_sel_unexpected", 1, 0);
                end else begin
                    s = sq.pop_front();
                    chk("decay_sel", int'(decay_sel_o), s);
                end
            end
            while (gq.size() > 0 && gq[0].cyc < mk) begin
                e = gq.pop_front();
                chk("grant_missed", 0, int'(e.g));
            end
            eg = 4'b0000;
            if (gq.size() > 0 && gq[0].cyc == mk) begin
                e  = gq.pop_front();
                eg = e.g;
            end
            chk("grant", int'(grant_o), int'(eg));
        end
    end

    task automatic model_reset();
        k         = 0;
        idle_from = 0;
        grant_cyc = -1;
        ptr       = 0;
        msel      = 0;
    endtask

    // Apply inputs for cycle k (called at a negedge), update the model, advance one cycle.
    task automatic step(input logic [3:0] r, input logic s);
        logic [3:0] re;
        int         exp_state;
        int         w;
        int         j;
        req      = r;
        sleeping = s;
        exp_state = (k >= idle_from) ? 0 : ((k == grant_cyc) ? 1 : 2);
        chk("state", int'(state_o), exp_state);
        if (is_decay(k)) begin
            msel = (msel + 1) % 5;
`ifdef PET_SLEEP_LOCK_EN
            if (s && msel == 1) msel = 2;
`endif
        end
        if (is_decay(k + 1)) sq.push_back(msel);
        if (k >= idle_from) begin
            re = r;
`ifdef PET_SLEEP_LOCK_EN
            if (s) re = r & 4'b1010;
`endif
            if (re != 4'b0000 && !is_decay(k)) begin
                w = -1;
                for (int i = 0; i < 4; i++) begin
                    if (w < 0 && re[(ptr + i) % 4]) w = (ptr + i) % 4;
                end
                gq.push_back('{cyc: k + 1, g: 4'(4'b0001 << w)});
                ptr       = (w + 1) % 4;
                grant_cyc = k + 1;
                if (CD == 0) begin
                    idle_from = k + 2;
                end else begin
                    j = k + 2;
                    while ((j % TD) != TD - 1) j++;
                    idle_from = j + TD * (CD - 1) + 1;
                end
            end
        end
        @(negedge clk);
        k++;
    endtask

    task automatic wait_idle(input bit want_decay);
        int n = 0;
        while (!((k >= idle_from) && (is_decay(k) == want_decay)) && n < 64) begin
            step(4'b0000, sleeping);
            n++;
        end
        chk("wait_bound", int'(n < 64), 1);
    endtask

    logic [3:0] rr;
    logic       rs;

    initial begin
        #1;
        chk("rst_state", int'(state_o), 0);
        chk("rst_grant", int'(grant_o), 0);
        chk("rst_decay_stb", int'(decay_stb_o), 0);
        chk("rst_decay_sel", int'(decay_sel_o), 0);
        chk("rst_sec_tick", int'(sec_tick_o), 0);
        @(negedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
        model_reset();

        // Idle run: ticks, decay strobes and selector rotation only
        repeat (44) step(4'b0000, 1'b0);

        // Single-cycle feed request
        wait_idle(1'b0);
        step(4'b0001, 1'b0);
        repeat (10) step(4'b0000, 1'b0);

        // All requests held: round-robin service
        repeat (40) step(4'b1111, 1'b0);
        repeat (6) step(4'b0000, 1'b0);

        // Request arriving in a decay strobe cycle is deferred one cycle
        wait_idle(1'b1);
        repeat (3) step(4'b0100, 1'b0);
        repeat (6) step(4'b0000, 1'b0);

        // Asynchronous reset during cooldown
        wait_idle(1'b0);
        step(4'b0001, 1'b0);
        step(4'b0000, 1'b0);
        chk("pre_rst_cooldown", int'(state_o), 2);
        #2;
        rst_ni = 1'b0;
        gq.delete();
        sq.delete();
        #1;
        chk("async_rst_state", int'(state_o), 0);
        chk("async_rst_grant", int'(grant_o), 0);
        chk("async_rst_decay_stb", int'(decay_stb_o), 0);
        chk("async_rst_decay_sel", int'(decay_sel_o), 0);
        chk("async_rst_sec_tick", int'(sec_tick_o), 0);
        @(negedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
        model_reset();
        step(4'b0010, 1'b0);
        repeat (8) step(4'b0000, 1'b0);

`ifdef PET_SLEEP_LOCK_EN
        // Asleep: feed/play masked, heal allowed, sleep stat skipped in decay rotation
        repeat (30) step(4'b0101, 1'b1);
        wait_idle(1'b0);
        step(4'b0010, 1'b1);
        repeat (50) step(4'b0000, 1'b1);
`endif

        // Randomized phase
        rr = 4'b0000;
        rs = 1'b0;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 3) == 0) rr = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 49) == 0) rs = ~rs;
            step(rr, rs);
        end

        repeat (16) step(4'b0000, 1'b0);
        #2;
        chk("grant_queue_drained", gq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
